// File: rtl/binary_decoder_strobe_if.sv
// rtl/binary_decoder_strobe_if.sv - request/strobe bundle for binary_decoder_strobe
interface binary_decoder_strobe_if #(
    parameter int WIDTH = 5
);
    localparam int ADDR_WIDTH = $clog2(WIDTH);

    logic                  i_valid;
    logic                  i_enable;
    logic [ADDR_WIDTH-1:0] iv_addr;
    logic                  o_ready;
    logic [WIDTH-1:0]      ov_output;
    logic                  o_busy;
    logic                  o_error;

    modport master (
        output i_valid, i_enable, iv_addr,
        input  o_ready, ov_output, o_busy, o_error
    );

    modport slave (
        input  i_valid, i_enable, iv_addr,
        output o_ready, ov_output, o_busy, o_error
    );
endinterface

// File: rtl/binary_decoder_strobe.sv
// rtl/binary_decoder_strobe.sv - registered binary-to-one-hot decoder holding each line HOLD cycles
module binary_decoder_strobe #(
    parameter int WIDTH = 5,
    parameter int HOLD  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    binary_decoder_strobe_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(WIDTH);
    localparam int CNT_WIDTH  = ($clog2(HOLD + 1) < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [ADDR_WIDTH:0]  WIDTH_L   = WIDTH[ADDR_WIDTH:0];
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD - 1);

    typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic                  err_q, err_d;
    logic                  ready;
    logic                  accept;
    logic                  addr_ok;
    logic [WIDTH-1:0]      one_hot;

    // A HOLD line whose counter has run out may be replaced in the same cycle.
    assign ready   = i_rst_n & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & (cnt_q == '0)));
    assign accept  = bus.i_valid & ready;
    assign addr_ok = ({1'b0, bus.iv_addr} < WIDTH_L);
    assign one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << bus.iv_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = 1'b0;
        if ((state_q == ST_HOLD) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end else if (accept) begin
            if (bus.i_enable && addr_ok) begin
                out_d   = one_hot;
                cnt_d   = HOLD_LOAD;
                state_d = ST_HOLD;
            end else begin
                // Disabled or out-of-range requests are consumed without a strobe.
                out_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
                err_d   = bus.i_enable;
            end
        end else begin
            out_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.ov_output = out_q;
    assign bus.o_busy    = (state_q == ST_HOLD);
    assign bus.o_error   = err_q;
endmodule

// File: tb/tb_binary_decoder_strobe.sv
// tb/tb_binary_decoder_strobe.sv - scoreboard bench for binary_decoder_strobe, HOLD=1 and HOLD=3
module tb_binary_decoder_strobe;
    localparam int WIDTH = 5;
    localparam int AW    = $clog2(WIDTH);

    typedef struct {
        logic [WIDTH-1:0] out;
        logic             busy;
        logic             err;
        logic             rdy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] addr = '0;

    int   n_vec = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   holds[2] = '{1, 3};
    int   left[2]  = '{0, 0};
    int   line[2]  = '{0, 0};

    always #5 clk = ~clk;

    binary_decoder_strobe_if #(.WIDTH(WIDTH)) bus_a ();
    binary_decoder_strobe_if #(.WIDTH(WIDTH)) bus_b ();

    assign bus_a.i_valid  = valid;
    assign bus_a.i_enable = enable;
    assign bus_a.iv_addr  = addr;
    assign bus_b.i_valid  = valid;
    assign bus_b.i_enable = enable;
    assign bus_b.iv_addr  = addr;

    binary_decoder_strobe #(.WIDTH(WIDTH), .HOLD(1)) dut_h1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a.slave)
    );

    binary_decoder_strobe #(.WIDTH(WIDTH), .HOLD(3)) dut_h3 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a line is "left" cycles from release; ready once at most one cycle remains.
    task automatic model_step(input int k, input logic v, input logic en, input int a, output exp_t e);
        logic acc;
        e.err = 1'b0;
        acc = v && (left[k] <= 1);
        if (acc) begin
            if (en && a < WIDTH) begin
                line[k] = a;
                left[k] = holds[k];
            end else begin
                left[k] = 0;
                e.err   = en;
            end
        end else if (left[k] > 0) begin
            left[k]--;
        end
        e.out = '0;
        if (left[k] > 0) e.out[line[k]] = 1'b1;
        e.busy = (left[k] > 0);
        e.rdy  = (left[k] <= 1);
    endtask

    task automatic apply(input logic v, input logic en, input int a);
        exp_t ea, eb;
        @(negedge clk);
        valid  = v;
        enable = en;
        addr   = AW'(a);
        model_step(0, v, en, a, ea);
        model_step(1, v, en, a, eb);
        q0.push_back(ea);
        q1.push_back(eb);
        n_vec++;
        mon_en = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk("h1_out",   32'(bus_a.ov_output), 32'(e0.out));
            chk("h1_busy",  32'(bus_a.o_busy),    32'(e0.busy));
            chk("h1_err",   32'(bus_a.o_error),   32'(e0.err));
            chk("h1_ready", 32'(bus_a.o_ready),   32'(e0.rdy));
            chk("h1_onehot0", 32'($countones(bus_a.ov_output) <= 1), 32'd1);
        end else if (mon_en) begin
            chk("h1_queue_empty", 32'(q0.size()), 32'd1);
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk("h3_out",   32'(bus_b.ov_output), 32'(e1.out));
            chk("h3_busy",  32'(bus_b.o_busy),    32'(e1.busy));
            chk("h3_err",   32'(bus_b.o_error),   32'(e1.err));
            chk("h3_ready", 32'(bus_b.o_ready),   32'(e1.rdy));
            chk("h3_onehot0", 32'($countones(bus_b.ov_output) <= 1), 32'd1);
        end else if (mon_en) begin
            chk("h3_queue_empty", 32'(q1.size()), 32'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        repeat (2) @(negedge clk);
        chk("rst_h1_ready", 32'(bus_a.o_ready),   32'd0);
        chk("rst_h3_ready", 32'(bus_b.o_ready),   32'd0);
        chk("rst_h3_out",   32'(bus_b.ov_output), 32'd0);
        chk("rst_h3_busy",  32'(bus_b.o_busy),    32'd0);
        chk("rst_h3_err",   32'(bus_b.o_error),   32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_h1_ready", 32'(bus_a.o_ready), 32'd1);
        chk("rel_h3_ready", 32'(bus_b.o_ready), 32'd1);

        // consecutive addresses, then held valid switching line, then error/disabled cases
        for (int i = 0; i < WIDTH; i++) apply(1'b1, 1'b1, i);
        repeat (4) apply(1'b0, 1'b0, 0);
        apply(1'b1, 1'b1, 2);
        repeat (4) apply(1'b0, 1'b1, 2);
        apply(1'b1, 1'b1, 1);
        repeat (3) apply(1'b1, 1'b1, 4);
        repeat (4) apply(1'b0, 1'b0, 0);
        apply(1'b1, 1'b1, 6);
        apply(1'b0, 1'b0, 0);
        apply(1'b1, 1'b0, 6);
        apply(1'b1, 1'b1, 7);
        apply(1'b1, 1'b1, 5);
        repeat (2) apply(1'b0, 1'b0, 0);

        // asynchronous reset in the middle of a hold
        apply(1'b1, 1'b1, 3);
        apply(1'b0, 1'b0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        left  = '{0, 0};
        #1;
        chk("midrst_h3_out",   32'(bus_b.ov_output), 32'd0);
        chk("midrst_h3_busy",  32'(bus_b.o_busy),    32'd0);
        chk("midrst_h3_ready", 32'(bus_b.o_ready),   32'd0);
        chk("midrst_h1_ready", 32'(bus_a.o_ready),   32'd0);
        z.out = '0; z.busy = 1'b0; z.err = 1'b0; z.rdy = 1'b0;
        q0.push_back(z);
        q1.push_back(z);
        @(negedge clk);
        rst_n = 1'b1;
        z.rdy = 1'b1;
        q0.push_back(z);
        q1.push_back(z);
        n_vec++;

        for (int i = 0; i < 3000; i++)
            apply(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)));
        repeat (4) apply(1'b0, 1'b0, 0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
